cnt_attr_arb: RTL and testbench

//  Arbitrated front end for the shared 16-bit max/decrement counter ("attr counter").
//  N requesters offer 16-bit samples over valid/ready. One winner per cycle, chosen round-robin, updates the counter:

---
 rtl/cnt_attr_arb_pkg.sv | 28 ++
 rtl/cnt_attr_arb_if.sv | 23 ++
 rtl/cnt_attr_rr_arb.sv | 32 +++
 rtl/cnt_attr_arb.sv | 112 +++++++++++
 tb/tb_cnt_attr_arb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnt_attr_arb_pkg.sv
// Shared types and helpers for the arbitrated attr counter front end.
// Holds the counter width, the update rule and the update-source encoding.
package cnt_attr_pkg;

  localparam int unsigned CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // Flag bit placed in the MSB of upd_src for decay and clear events
  localparam logic UPD_SRC_DECAY = 1'b1;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_XFER,
    EV_DECAY,
    EV_CLEAR
  } upd_kind_e;

  // Max-or-decrement: a larger sample replaces the count; otherwise step down with wrap
  function automatic cnt_t attr_update(cnt_t cur, cnt_t sample);
    return (sample > cur) ? sample : cnt_t'(cur - 1'b1);
  endfunction

  function automatic cnt_t attr_decrement(cnt_t cur);
    return cnt_t'(cur - 1'b1);
  endfunction

endpackage

// File: rtl/cnt_attr_arb_if.sv
// Requester-side valid/ready bundle: producers drive valid/data, the arbiter drives ready.
interface cnt_attr_arb_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 16
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*CNT_W-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/cnt_attr_rr_arb.sv
// Round-robin arbiter: scans from ptr_i upward with wrap, grants the first requesting lane.
module cnt_attr_rr_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

  always_comb begin
    int unsigned lane;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    lane  = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      lane = 32'(ptr_i) + off;
      if (lane >= N_REQ) begin
        lane = lane - N_REQ;
      end
      if (!any_o && req_i[lane]) begin
        any_o       = 1'b1;
        gnt_o[lane] = 1'b1;
        idx_o       = PTR_W'(lane);
      end
    end
  end

endmodule

// File: rtl/cnt_attr_arb.sv
// Arbitrated max/decrement attr counter with idle-decay timer.
// One round-robin winner per cycle updates the count; clear beats transfer beats decay.
module cnt_attr_arb
  import cnt_attr_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DECAY_PERIOD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    decay_en_i,
    cnt_attr_arb_if.slave           req_if,
    output cnt_t                    cnt_out_o,
    output logic                    upd_valid_o,
    output logic [$clog2(N_REQ):0]  upd_src_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned SRC_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(DECAY_PERIOD + 1);

  cnt_t             cnt_q, cnt_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             upd_valid_q, upd_valid_d;
  logic [SRC_W-1:0] upd_src_q, upd_src_d;

  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             xfer;
  cnt_t             sample;
  upd_kind_e        kind;

  cnt_attr_rr_arb #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i (req_if.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Clear and reset mask the grant so no transfer can be accepted on those cycles
  assign req_if.req_ready = (rst || clear_i) ? '0 : gnt;
  assign xfer             = gnt_any && !clear_i;
  assign sample           = req_if.req_data[gnt_idx*CNT_W +: CNT_W];

  always_comb begin
    kind = EV_NONE;
    if (clear_i) begin
      kind = EV_CLEAR;
    end else if (xfer) begin
      kind = EV_XFER;
    end else if (decay_en_i && (tmr_q == TMR_W'(DECAY_PERIOD - 1))) begin
      kind = EV_DECAY;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    tmr_d       = '0;
    upd_valid_d = 1'b0;
    upd_src_d   = upd_src_q;
    unique case (kind)
      EV_CLEAR: begin
        cnt_d       = '0;
        upd_valid_d = 1'b1;
        upd_src_d   = {UPD_SRC_DECAY, PTR_W'(0)};
      end
      EV_XFER: begin
        cnt_d       = attr_update(cnt_q, sample);
        rr_ptr_d    = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : PTR_W'(gnt_idx + 1'b1);
        upd_valid_d = 1'b1;
        upd_src_d   = {1'b0, gnt_idx};
      end
      EV_DECAY: begin
        cnt_d       = attr_decrement(cnt_q);
        upd_valid_d = 1'b1;
        upd_src_d   = {UPD_SRC_DECAY, PTR_W'(0)};
      end
      default: begin
        tmr_d = decay_en_i ? TMR_W'(tmr_q + 1'b1) : '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      tmr_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_src_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      tmr_q       <= tmr_d;
      upd_valid_q <= upd_valid_d;
      upd_src_q   <= upd_src_d;
    end
  end

  assign cnt_out_o   = cnt_q;
  assign upd_valid_o = upd_valid_q;
  assign upd_src_o   = upd_src_q;

endmodule

// File: tb/tb_cnt_attr_arb.sv
// Bench for cnt_attr_arb: constant vector table, directed corner sequences, random vs reference model.
module tb_cnt_attr_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned EV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        decay_en;
  logic [15:0] cnt_out;
  logic        upd_valid;
  logic [2:0]  upd_src;

  cnt_attr_arb_if #(.N_REQ(N), .CNT_W(16)) rif ();

  cnt_attr_arb #(.N_REQ(N), .DECAY_PERIOD(DP)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .decay_en_i  (decay_en),
    .req_if      (rif.slave),
    .cnt_out_o   (cnt_out),
    .upd_valid_o (upd_valid),
    .upd_src_o   (upd_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned m_cnt, m_ptr, m_tmr, m_src;
  logic        m_uv;

  typedef struct {
    logic        clr;
    logic [3:0]  v;
    logic [63:0] d;
    logic [3:0]  rdy;
    logic [15:0] cnt;
    logic        uv;
    logic [2:0]  src;
  } vec_t;

  vec_t tab[17];

  function automatic logic [63:0] ln(int lane, logic [15:0] val);
    logic [63:0] r;
    r = '0;
    r[lane*16 +: 16] = val;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle from posedge+1, sample ready mid-cycle, return at next posedge+1
  task automatic cycle(input logic clr, input logic den, input logic [3:0] v,
                       input logic [63:0] d, output logic [3:0] rdy);
    clear             = clr;
    decay_en          = den;
    rif.req_valid     = v;
    rif.req_data      = d;
    #2;
    rdy = rif.req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_tmr = 0; m_src = 0; m_uv = 1'b0;
  endtask

  // Reference: counts idle cycles and wraps the count modulo 2^16 with plain arithmetic
  task automatic model_step(input logic clr, input logic den, input logic [3:0] v,
                            input logic [63:0] d, output logic [3:0] erdy);
    int g;
    int unsigned s;
    g = -1;
    erdy = '0;
    if (!clr) begin
      for (int k = 0; k < int'(N); k++) begin
        int lane;
        lane = (int'(m_ptr) + k) % int'(N);
        if (g < 0 && v[lane]) g = lane;
      end
    end
    if (clr) begin
      m_cnt = 0; m_tmr = 0; m_uv = 1'b1; m_src = EV;
    end else if (g >= 0) begin
      erdy[g] = 1'b1;
      s = 32'(d[g*16 +: 16]);
      m_cnt = (s > m_cnt) ? s : (m_cnt + 65535) % 65536;
      m_ptr = (g + 1) % N;
      m_tmr = 0; m_uv = 1'b1; m_src = g;
    end else if (den) begin
      m_tmr++;
      if (m_tmr == DP) begin
        m_cnt = (m_cnt + 65535) % 65536;
        m_tmr = 0; m_uv = 1'b1; m_src = EV;
      end else begin
        m_uv = 1'b0;
      end
    end else begin
      m_tmr = 0; m_uv = 1'b0;
    end
  endtask

  initial begin
    logic [3:0]  rdy, erdy, pv;
    logic [63:0] pd;
    logic        rclr, rden;

    tab[0]  = '{1'b0, 4'b0000, 64'h0,                      4'b0000, 16'h0000, 1'b0, 3'd0};
    tab[1]  = '{1'b0, 4'b0100, ln(2, 16'h0005),            4'b0100, 16'h0005, 1'b1, 3'd2};
    tab[2]  = '{1'b0, 4'b0100, ln(2, 16'h0010),            4'b0100, 16'h0010, 1'b1, 3'd2};
    tab[3]  = '{1'b0, 4'b0100, ln(2, 16'h0003),            4'b0100, 16'h000F, 1'b1, 3'd2};
    tab[4]  = '{1'b1, 4'b1000, ln(3, 16'h0055),            4'b0000, 16'h0000, 1'b1, 3'd4};
    tab[5]  = '{1'b0, 4'b1000, ln(3, 16'h0055),            4'b1000, 16'h0055, 1'b1, 3'd3};
    tab[6]  = '{1'b1, 4'b0000, 64'h0,                      4'b0000, 16'h0000, 1'b1, 3'd4};
    tab[7]  = '{1'b0, 4'b0010, ln(1, 16'h0000),            4'b0010, 16'hFFFF, 1'b1, 3'd1};
    tab[8]  = '{1'b0, 4'b1000, ln(3, 16'h0000),            4'b1000, 16'hFFFE, 1'b1, 3'd3};
    tab[9]  = '{1'b0, 4'b1111, 64'h0,                      4'b0001, 16'hFFFD, 1'b1, 3'd0};
    tab[10] = '{1'b0, 4'b1111, 64'h0,                      4'b0010, 16'hFFFC, 1'b1, 3'd1};
    tab[11] = '{1'b0, 4'b1111, 64'h0,                      4'b0100, 16'hFFFB, 1'b1, 3'd2};
    tab[12] = '{1'b0, 4'b1111, 64'h0,                      4'b1000, 16'hFFFA, 1'b1, 3'd3};
    tab[13] = '{1'b0, 4'b1111, 64'h0,                      4'b0001, 16'hFFF9, 1'b1, 3'd0};
    tab[14] = '{1'b0, 4'b1010, ln(1, 16'hFFFF) | ln(3, 16'h1234), 4'b0010, 16'hFFFF, 1'b1, 3'd1};
    tab[15] = '{1'b0, 4'b1000, ln(3, 16'h1234),            4'b1000, 16'hFFFE, 1'b1, 3'd3};
    tab[16] = '{1'b0, 4'b0001, ln(0, 16'hFFFE),            4'b0001, 16'hFFFD, 1'b1, 3'd0};

    rst = 1'b1; clear = 1'b0; decay_en = 1'b0;
    rif.req_valid = 4'b0001; rif.req_data = ln(0, 16'h0100);
    @(posedge clk); #1;
    chk("reset_cnt", 32'(cnt_out), 32'h0);
    chk("reset_uv", 32'(upd_valid), 32'h0);
    chk("reset_src", 32'(upd_src), 32'h0);
    chk("reset_rdy", 32'(rif.req_ready), 32'h0);
    rif.req_valid = '0; rif.req_data = '0;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      cycle(tab[i].clr, 1'b0, tab[i].v, tab[i].d, rdy);
      chk($sformatf("tab%0d_rdy", i), 32'(rdy), 32'(tab[i].rdy));
      chk($sformatf("tab%0d_cnt", i), 32'(cnt_out), 32'(tab[i].cnt));
      chk($sformatf("tab%0d_uv", i), 32'(upd_valid), 32'(tab[i].uv));
      if (tab[i].uv) chk($sformatf("tab%0d_src", i), 32'(upd_src), 32'(tab[i].src));
    end

    // Asynchronous reset mid-cycle while lane0 is offering a sample
    rif.req_valid = 4'b0001; rif.req_data = ln(0, 16'h0100);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt_out), 32'h0);
    chk("async_rst_rdy", 32'(rif.req_ready), 32'h0);
    chk("async_rst_uv", 32'(upd_valid), 32'h0);
    @(posedge clk); #1;
    rif.req_valid = '0;
    rst = 1'b0;
    chk("async_rst_hold", 32'(cnt_out), 32'h0);

    cycle(1'b0, 1'b0, 4'b0001, ln(0, 16'h0020), rdy);
    chk("decay_load", 32'(cnt_out), 32'h20);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 4'b0000, 64'h0, rdy);
      chk($sformatf("decay_idle%0d", i), 32'(cnt_out), 32'h20);
      chk($sformatf("decay_idle%0d_uv", i), 32'(upd_valid), 32'h0);
    end
    cycle(1'b0, 1'b1, 4'b0000, 64'h0, rdy);
    chk("decay_fire_cnt", 32'(cnt_out), 32'h1F);
    chk("decay_fire_uv", 32'(upd_valid), 32'h1);
    chk("decay_fire_src", 32'(upd_src), 32'(EV));
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 4'b0000, 64'h0, rdy);
    chk("supp_pre", 32'(cnt_out), 32'h1F);
    cycle(1'b0, 1'b1, 4'b0010, ln(1, 16'h0000), rdy);
    chk("supp_xfer_rdy", 32'(rdy), 32'h2);
    chk("supp_xfer_cnt", 32'(cnt_out), 32'h1E);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 4'b0000, 64'h0, rdy);
      chk($sformatf("supp_idle%0d", i), 32'(cnt_out), 32'h1E);
    end
    cycle(1'b0, 1'b1, 4'b0000, 64'h0, rdy);
    chk("supp_fire_cnt", 32'(cnt_out), 32'h1D);
    chk("supp_fire_src", 32'(upd_src), 32'(EV));

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    pv = '0; pd = '0;
    for (int i = 0; i < 600; i++) begin
      bit quiet;
      quiet = ((i / 40) % 2) == 1;
      for (int l = 0; l < int'(N); l++) begin
        if (!pv[l] && ($urandom_range(0, quiet ? 30 : 2) == 0)) begin
          pv[l] = 1'b1;
          case ($urandom_range(0, 3))
            0: pd[l*16 +: 16] = 16'($urandom);
            1: pd[l*16 +: 16] = 16'(m_cnt);
            2: pd[l*16 +: 16] = 16'h0000;
            default: pd[l*16 +: 16] = 16'(m_cnt + $urandom_range(1, 3));
          endcase
        end
      end
      rclr = ($urandom_range(0, 24) == 0);
      rden = ($urandom_range(0, 5) != 0);
      model_step(rclr, rden, pv, pd, erdy);
      cycle(rclr, rden, pv, pd, rdy);
      chk("rnd_rdy", 32'(rdy), 32'(erdy));
      chk("rnd_cnt", 32'(cnt_out), m_cnt);
      chk("rnd_uv", 32'(upd_valid), 32'(m_uv));
      if (m_uv) chk("rnd_src", 32'(upd_src), m_src);
      pv = pv & ~erdy;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
